// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a small word-addressed register-file memory.
// Handles single NONSEQ transfers, stretches each OKAY completion by a fixed
// number of wait states, and signals out-of-range addresses with a two-cycle
// ERROR response. Address phases are pipelined into DONE and ERR2 cycles.
module ahb_sram_slave #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [31:0] DEPTH_W       = 32'(DEPTH);
  // The counter is loaded one below the wait count: it reaches zero in the
  // last wait cycle, so the following edge moves to DONE.
  localparam logic [3:0]  WAIT_LOAD     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic                addrOk;
  logic                memWrite;

  // Bus-facing outputs depend only on the current state and latched request.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state_q)
      S_WAIT: begin
        hready = 1'b0;
      end
      S_DONE: begin
        if (!write_q) begin
          hrdata = mem_q[addr_q];
        end
      end
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      S_ERR2: begin
        hresp = 1'b1;
      end
      default: begin
        hready = 1'b1;
      end
    endcase
  end

  // A transfer is accepted only while this slave is ready, so a pending
  // address phase is held off during WAIT and ERR1. The full 32-bit index is
  // range-checked so nonzero upper bits never alias onto a valid word.
  always_comb begin
    accept   = hsel && (htrans == HTRANS_NONSEQ) && hready;
    addrOk   = (haddr < DEPTH_W);
    memWrite = (state_q == S_DONE) && write_q;
  end

  // Next-state logic: IDLE, DONE and ERR2 all evaluate a new address phase
  // identically, so they share one branch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          addr_d  = haddr[ADDR_W-1:0];
          write_d = hwrite;
          if (!addrOk) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; an asynchronous reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  // Memory array: cleared on reset, written at the edge that ends a write's
  // DONE cycle, so a read pipelined behind it already sees the new data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (memWrite) begin
      mem_q[addr_q] <= hwdata;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: a table of single transfers on a
// two-wait-state instance, plus hand-written pipelined, reset and
// zero-wait-state sequences.
module tb_ahb_sram_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expLow;
    logic        expResp;
    logic [31:0] expRdata;
  } vector_t;

  logic        clk = 1'b0;
  logic        nRst;

  logic        hselA, hwriteA, readyA, respA;
  logic [1:0]  htransA;
  logic [31:0] haddrA, hwdataA, rdataA;

  logic        hselB, hwriteB, readyB, respB;
  logic [1:0]  htransB;
  logic [31:0] haddrB, hwdataB, rdataB;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [16];
  vector_t     vecs [9];

  always #5 clk = ~clk;

  ahb_sram_slave #(.DEPTH(16), .ADDR_W(4), .WAIT_STATES(2)) dutA (
    .clk(clk), .n_rst(nRst), .hsel(hselA), .htrans(htransA), .haddr(haddrA),
    .hwrite(hwriteA), .hwdata(hwdataA), .hrdata(rdataA), .hready(readyA), .hresp(respA)
  );

  ahb_sram_slave #(.DEPTH(16), .ADDR_W(4), .WAIT_STATES(0)) dutB (
    .clk(clk), .n_rst(nRst), .hsel(hselB), .htrans(htransB), .haddr(haddrB),
    .hwrite(hwriteB), .hwdata(hwdataB), .hrdata(rdataB), .hready(readyB), .hresp(respB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Drive an address phase on instance A; write data is only updated for writes.
  task automatic issueA(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    hselA   = 1'b1;
    htransA = 2'b10;
    haddrA  = addr;
    hwriteA = wr;
    if (wr) hwdataA = wd;
  endtask

  // Let the accept edge pass, scramble the address-phase signals (they must
  // be ignored), then wait (bounded) for the completing cycle.
  task automatic waitDoneA(output int lowCycles, output logic respLow, output logic respHigh,
                           output logic [31:0] rd);
    @(negedge clk);
    hselA   = 1'b0;
    htransA = 2'b00;
    haddrA  = haddrA ^ 32'h1;
    hwriteA = ~hwriteA;
    lowCycles = 0;
    respLow   = 1'b0;
    while (readyA !== 1'b1 && lowCycles < 20) begin
      if (respA === 1'b1) respLow = 1'b1;
      lowCycles++;
      @(negedge clk);
    end
    respHigh = respA;
    rd       = rdataA;
  endtask

  task automatic applyStimulus(input vector_t v, input string name);
    int          low;
    logic        rLow, rHigh;
    logic [31:0] rd;
    @(negedge clk);
    issueA(v.wr, v.addr, v.wdata);
    waitDoneA(low, rLow, rHigh, rd);
    checkOutput({name, " lowCycles"}, 32'(low), 32'(v.expLow));
    checkOutput({name, " respDuringWait"}, {31'd0, rLow}, {31'd0, v.expResp});
    checkOutput({name, " respDone"}, {31'd0, rHigh}, {31'd0, v.expResp});
    checkOutput({name, " rdata"}, rd, v.expRdata);
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp, input string name);
    vector_t v;
    v = '{1'b0, addr, 32'd0, 2, 1'b0, exp};
    applyStimulus(v, name);
  endtask

  initial begin
    int          low;
    logic        rLow, rHigh;
    logic [31:0] rd;
    logic [31:0] valsB [4];

    valsB[0] = 32'hFFFFFFFF;
    valsB[1] = 32'h00000000;
    valsB[2] = 32'hAAAAAAAA;
    valsB[3] = 32'h55555555;

    vecs[0] = '{1'b0, 32'd5,          32'h00000000, 2, 1'b0, 32'h00000000};
    vecs[1] = '{1'b1, 32'd3,          32'hAAAAAAAA, 2, 1'b0, 32'h00000000};
    vecs[2] = '{1'b0, 32'd3,          32'h00000000, 2, 1'b0, 32'hAAAAAAAA};
    vecs[3] = '{1'b1, 32'h00000010,   32'h12345678, 1, 1'b1, 32'h00000000};
    vecs[4] = '{1'b1, 32'h00010003,   32'hDEADBEEF, 1, 1'b1, 32'h00000000};
    vecs[5] = '{1'b0, 32'd15,         32'h00000000, 2, 1'b0, 32'h00000000};
    vecs[6] = '{1'b1, 32'd15,         32'h0F0F0F0F, 2, 1'b0, 32'h00000000};
    vecs[7] = '{1'b0, 32'd15,         32'h00000000, 2, 1'b0, 32'h0F0F0F0F};
    vecs[8] = '{1'b0, 32'd3,          32'h00000000, 2, 1'b0, 32'hAAAAAAAA};

    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    model[3]  = 32'hAAAAAAAA;
    model[15] = 32'h0F0F0F0F;

    hselA = 0; htransA = 0; haddrA = 0; hwriteA = 0; hwdataA = 0;
    hselB = 0; htransB = 0; haddrB = 0; hwriteB = 0; hwdataB = 0;
    nRst = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset hready", {31'd0, readyA}, 32'd1);
    checkOutput("reset hresp", {31'd0, respA}, 32'd0);
    checkOutput("reset hrdata", rdataA, 32'd0);
    nRst = 1'b1;
    @(negedge clk);
    checkOutput("idle hready", {31'd0, readyA}, 32'd1);
    checkOutput("idle hresp", {31'd0, respA}, 32'd0);
    checkOutput("idle hrdata", rdataA, 32'd0);
    checkOutput("idle B hready", {31'd0, readyB}, 32'd1);

    // Table-driven single transfers
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Errored writes must leave every word untouched
    for (int a = 0; a < 16; a++) begin
      readCheck(32'(a), model[a], $sformatf("readback%0d", a));
    end

    // Back-to-back: read of addr 1 accepted in the write's DONE cycle
    @(negedge clk);
    issueA(1'b1, 32'd1, 32'h55555555);
    waitDoneA(low, rLow, rHigh, rd);
    checkOutput("b2b write lowCycles", 32'(low), 32'd2);
    issueA(1'b0, 32'd1, 32'h0);
    waitDoneA(low, rLow, rHigh, rd);
    checkOutput("b2b read lowCycles", 32'(low), 32'd2);
    checkOutput("b2b read resp", {31'd0, rHigh}, 32'd0);
    checkOutput("b2b read rdata", rd, 32'h55555555);

    // Reset asserted during the WAIT of a write
    @(negedge clk);
    issueA(1'b1, 32'd2, 32'hFFFFFFFF);
    @(negedge clk);
    hselA = 1'b0;
    htransA = 2'b00;
    checkOutput("rstmid in wait", {31'd0, readyA}, 32'd0);
    #2 nRst = 1'b0;
    #1;
    checkOutput("rstmid hready", {31'd0, readyA}, 32'd1);
    checkOutput("rstmid hresp", {31'd0, respA}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    readCheck(32'd2, 32'h0, "rstmid addr2");
    readCheck(32'd1, 32'h0, "rstmid addr1 cleared");
    readCheck(32'd3, 32'h0, "rstmid addr3 cleared");

    // Zero wait states: pipelined writes, data phase trails address by one cycle
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ws0 wr%0d hready", k), {31'd0, readyB}, 32'd1);
      checkOutput($sformatf("ws0 wr%0d hresp", k), {31'd0, respB}, 32'd0);
      if (k < 4) begin
        hselB = 1'b1; htransB = 2'b10; haddrB = 32'(k); hwriteB = 1'b1;
      end else begin
        hselB = 1'b0; htransB = 2'b00;
      end
      if (k > 0) hwdataB = valsB[k-1];
    end
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ws0 rd%0d hready", k), {31'd0, readyB}, 32'd1);
      if (k > 0) checkOutput($sformatf("ws0 rd%0d rdata", k - 1), rdataB, valsB[k-1]);
      if (k < 4) begin
        hselB = 1'b1; htransB = 2'b10; haddrB = 32'(k); hwriteB = 1'b0;
      end else begin
        hselB = 1'b0; htransB = 2'b00;
      end
    end
    @(negedge clk);
    checkOutput("ws0 idle rdata", rdataB, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
